axi_stream_to_axi4_wr: RTL

Packs an AXI-Stream packet into a sequence of AXI4 INCR write bursts to consecutive memory addresses. It is the master-side stage that drives an `axi_inf.master_wr` port, sitting directly downstream of a stream cache. Each burst is collected in a local buffer before its AW is issued, so `awlen` is always exact. Bursts never cross a 4 KB boundary.

---
 rtl/axi_wr_pkg.sv | 12 +
 rtl/burst_buf_fifo.sv | 34 +++
 rtl/axi_stream_to_axi4_wr.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/axi_wr_pkg.sv
// axi_wr_pkg: shared AXI write constants, FSM states and 4 KB boundary helper
package axi_wr_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_AW, S_W, S_B} state_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int AXI_4K_BYTES = 4096;
  function automatic logic [12:0] beats_to_4k(input logic [11:0] addr, input int unsigned bytes_per_beat);
    int unsigned r;
    r = (32'(AXI_4K_BYTES) - 32'(addr)) / bytes_per_beat;
    return r[12:0];
  endfunction
endpackage

// File: rtl/burst_buf_fifo.sv
// burst_buf_fifo: first-word-fall-through buffer holding one burst ahead of its AW
module burst_buf_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);
  logic [WIDTH-1:0] mem_q [2**AW];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  always_ff @(posedge clock)
    if (push_i) mem_q[wr_q] <= din_i;
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end
  assign dout_o = mem_q[rd_q];
  assign empty_o = count_q == '0;
  assign count_o = count_q;
endmodule

// File: rtl/axi_stream_to_axi4_wr.sv
// axi_stream_to_axi4_wr: buffers an AXI-Stream packet into exact-length AXI4 INCR bursts
// that never cross a 4 KB boundary, one burst outstanding at a time.
module axi_stream_to_axi4_wr
  import axi_wr_pkg::*;
#(
  parameter int DSIZE = 64,
  parameter int ASIZE = 32,
  parameter int IDSIZE = 4,
  parameter int ID = 0,
  parameter int BURST_LEN = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  input  logic [ASIZE-1:0]  base_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       burst_cnt,
  input  logic [DSIZE-1:0]  axis_tdata,
  input  logic              axis_tvalid,
  input  logic              axis_tlast,
  output logic              axis_tready,
  output logic [IDSIZE-1:0] awid,
  output logic [ASIZE-1:0]  awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DSIZE-1:0]  wdata,
  output logic [DSIZE/8-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [IDSIZE-1:0] bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);
  localparam int BPB = DSIZE / 8;
  localparam int SZ = $clog2(BPB);
  localparam int FA = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  state_t state_q, state_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic [8:0] cnt_q, cnt_d;
  logic last_q, last_d, err_q, err_d, done_q, done_d, live_q;
  logic [15:0] bcnt_q, bcnt_d;
  logic [12:0] b4k, limit;
  logic push, pop, fempty;
  logic [FA:0] fcount;
  logic [DSIZE-1:0] fdout;
  logic unused;
  assign unused = ^{bid, bresp[0]};
  assign b4k = beats_to_4k(addr_q[11:0], BPB);
  assign limit = b4k < 13'(BURST_LEN) ? b4k : 13'(BURST_LEN);
  assign axis_tready = state_q == S_FILL;
  assign push = axis_tready && axis_tvalid;
  assign awvalid = state_q == S_AW;
  assign wvalid = state_q == S_W && !fempty;
  assign pop = wvalid && wready;
  // the buffer holds exactly one burst, so its final entry is the last beat
  assign wlast = wvalid && fcount == (FA+1)'(1);
  assign bready = state_q == S_B;
  assign awaddr = awvalid ? addr_q : '0;
  assign awlen = awvalid ? 8'(cnt_q - 9'd1) : '0;
  // constant fields read zero until the first clock after reset
  assign awsize = live_q ? 3'(SZ) : '0;
  assign awburst = live_q ? AXI_BURST_INCR : '0;
  assign awid = live_q ? IDSIZE'(ID) : '0;
  assign wstrb = live_q ? '1 : '0;
  assign wdata = wvalid ? fdout : '0;
  assign busy = state_q != S_IDLE || done_q;
  assign done = done_q;
  assign err = err_q;
  assign burst_cnt = bcnt_q;
  burst_buf_fifo #(.DEPTH(BURST_LEN), .WIDTH(DSIZE)) u_buf (
    .clock(clock),
    .rst(rst),
    .push_i(push),
    .din_i(axis_tdata),
    .pop_i(pop),
    .dout_o(fdout),
    .empty_o(fempty),
    .count_o(fcount)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    last_d = last_q;
    err_d = err_q;
    bcnt_d = bcnt_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (start && !done_q) begin
        state_d = S_FILL;
        addr_d = base_addr & ~ASIZE'(BPB - 1);
        err_d = 1'b0;
        bcnt_d = '0;
        cnt_d = '0;
        last_d = 1'b0;
      end
      S_FILL: if (push) begin
        cnt_d = cnt_q + 9'd1;
        if ({4'd0, cnt_d} == limit || axis_tlast) begin
          state_d = S_AW;
          last_d = axis_tlast;
        end
      end
      S_AW: if (awready) state_d = S_W;
      S_W: if (pop && wlast) state_d = S_B;
      S_B: if (bvalid) begin
        err_d = err_q | bresp[1];
        bcnt_d = bcnt_q + 16'd1;
        addr_d = addr_q + (ASIZE'(cnt_q) << SZ);
        cnt_d = '0;
        done_d = last_q;
        state_d = last_q ? S_IDLE : S_FILL;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      last_q <= 1'b0;
      err_q <= 1'b0;
      bcnt_q <= '0;
      done_q <= 1'b0;
      live_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      err_q <= err_d;
      bcnt_q <= bcnt_d;
      done_q <= done_d;
      live_q <= 1'b1;
    end
endmodule
